clint_ipi_dispatch: RTL

Hardware inter-processor-interrupt dispatcher that acts as a register-bus initiator towards the CLINT's `msip` registers. A local requester hands it a hart mask and a set/clear command. The block then issues one 32-bit write per selected hart, in ascending hart order, and reports completion and any bus errors. It sits in the peripheral domain beside the CLINT, driven by the system DMA/mailbox logic, so software does not need one store per hart.

---
 rtl/clint_ipi_dispatch.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/clint_ipi_dispatch.sv
// IPI dispatcher: writes msip[h] = set for every hart h selected in a mask, lowest index first.
// Define CLINT_IPI_READBACK_EN to read each msip back after the write and flag mismatches.

package clint_ipi_pkg;
  typedef struct packed {
    logic [47:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module clint_ipi_dispatch #(
  parameter type reg_req_t = clint_ipi_pkg::reg_req_t,
  parameter type reg_rsp_t = clint_ipi_pkg::reg_rsp_t,
  parameter int unsigned NrHarts = 33,
  parameter int unsigned AddrWidth = 48,
  parameter logic [AddrWidth-1:0] ClintBase = '0,
  localparam int unsigned HartW = (NrHarts > 1) ? $clog2(NrHarts) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [NrHarts-1:0] req_mask_i,
  input  logic               req_set_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [HartW-1:0]   err_hart_o,
  output logic [1:0]         dbg_state_o,
  output reg_req_t           reg_req_o,
  input  reg_rsp_t           reg_rsp_i
);

  // Command side: req_valid_i/req_ready_o transfer on a cycle where both are high.
  // Bus side: reg_req_o.valid stays high with all fields frozen until reg_rsp_i.ready.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
`ifdef CLINT_IPI_READBACK_EN
    , READ = 2'd3
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [NrHarts-1:0] pending_q, pending_d;
  logic               set_q, set_d;
  logic               err_q, err_d;
  logic [HartW-1:0]   err_hart_q, err_hart_d;

  logic [HartW-1:0]   hart_idx;
  logic [NrHarts-1:0] hart_onehot;
  logic [NrHarts-1:0] pending_clr;
  logic               rsp_bad;

  // Lowest set bit wins: scanning downward lets the smallest index overwrite.
  always_comb begin
    hart_idx = '0;
    for (int i = NrHarts - 1; i >= 0; i--) begin
      if (pending_q[i]) hart_idx = HartW'(i);
    end
  end

  assign hart_onehot = NrHarts'(1) << hart_idx;
  assign pending_clr = pending_q & ~hart_onehot;
  assign dbg_state_o = state_q;
  assign err_hart_o  = err_hart_q;

`ifndef CLINT_IPI_READBACK_EN
  logic unused_rdata;
  assign unused_rdata = ^reg_rsp_i.rdata;
`endif

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    set_d       = set_q;
    err_d       = err_q;
    err_hart_d  = err_hart_q;
    req_ready_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    err_o       = 1'b0;
    rsp_bad     = 1'b0;
    reg_req_o   = '0;

    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (req_valid_i) begin
          pending_d = req_mask_i;
          set_d     = req_set_i;
          err_d     = 1'b0;
          state_d   = (|req_mask_i) ? WRITE : DONE;
        end
      end
      WRITE: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.write = 1'b1;
        reg_req_o.addr  = ClintBase + (AddrWidth'(hart_idx) << 2);
        reg_req_o.wdata = {31'b0, set_q};
        reg_req_o.wstrb = 4'hF;
        if (reg_rsp_i.ready) begin
          rsp_bad = reg_rsp_i.error;
`ifdef CLINT_IPI_READBACK_EN
          // The pending bit is kept until the readback so hart_idx stays put.
          state_d = READ;
`else
          pending_d = pending_clr;
          state_d   = (|pending_clr) ? WRITE : DONE;
`endif
        end
      end
`ifdef CLINT_IPI_READBACK_EN
      READ: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.write = 1'b0;
        reg_req_o.addr  = ClintBase + (AddrWidth'(hart_idx) << 2);
        if (reg_rsp_i.ready) begin
          rsp_bad   = reg_rsp_i.error || (reg_rsp_i.rdata[0] != set_q);
          pending_d = pending_clr;
          state_d   = (|pending_clr) ? WRITE : DONE;
        end
      end
`endif
      DONE: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Only the first failing hart is recorded; later failures just keep err_q set.
    if (rsp_bad && !err_q) begin
      err_d      = 1'b1;
      err_hart_d = hart_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      set_q      <= 1'b0;
      err_q      <= 1'b0;
      err_hart_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      set_q      <= set_d;
      err_q      <= err_d;
      err_hart_q <= err_hart_d;
    end
  end

endmodule
